monitor_anel: RTL and testbench
===============================

MONITOR_ANEL -- requirements
Module: monitor_anel

Interface
REQ-001 SHALL have parameter: LAP_W, 8, width of the completed-lap counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset (reset=0 at a rising clk edge resets the block).
REQ-004 SHALL have port: ring_in  input  4  one-hot ring-counter word from the upstream stage.
REQ-005 SHALL have port: ring_valid  input  1  ring_in is sampled only when high.
REQ-006 SHALL have port: clr_err  input  1  one-cycle pulse clearing error, lap count and lock.
REQ-007 SHALL have port: pos  output  2  index of the set bit of the last accepted sample (0001->0, 0010->1, 0100->2, 1000->3).
REQ-008 SHALL have port: locked  output  1  high while in state LOCKED.
REQ-009 SHALL have port: lap_count  output  LAP_W  number of 1000->0001 wrap transitions seen while LOCKED.
REQ-010 SHALL have port: err  output  1  sticky error flag.
REQ-011 SHALL have port: err_code  output  2  cause of first error: 00 none, 01 not one-hot, 10 wrong step, 11 stall (repeat).

Function
REQ-012 SHALL implement a three-state FSM: UNLOCKED, LOCKED, ERROR.
REQ-013 All outputs SHALL be registered; the effect of a sample accepted at edge N SHALL be visible after edge N.
REQ-014 Cycles with ring_valid=0 SHALL change no state or output.
REQ-015 UNLOCKED: a valid one-hot sample SHALL load pos and move to LOCKED; a valid non-one-hot sample SHALL stay UNLOCKED with no error.
REQ-016 LOCKED: expected sample = previous accepted sample rotated left by one (1000 -> 0001).
REQ-017 LOCKED, sample equals expected: SHALL update pos; if previous was 1000 and sample is 0001, SHALL increment lap_count.
REQ-018 lap_count SHALL wrap from 2^LAP_W-1 to 0 without flagging an error.
REQ-019 LOCKED, sample not one-hot (zero or >1 bit set): SHALL set err=1, err_code=01, go ERROR.
REQ-020 LOCKED, one-hot sample equal to previous: SHALL set err=1, err_code=11, go ERROR.
REQ-021 LOCKED, any other one-hot mismatch: SHALL set err=1, err_code=10, go ERROR.
REQ-022 In ERROR, pos and lap_count SHALL hold; err/err_code SHALL hold first cause; further samples ignored.
REQ-023 clr_err=1 in any state SHALL clear err, err_code, lap_count, pos to 0 and go UNLOCKED; it SHALL take priority over a simultaneous valid sample, which is discarded.

Reset
REQ-024 reset=0 SHALL force state UNLOCKED, pos=0, locked=0, lap_count=0, err=0, err_code=00 at the next rising clk edge, overriding all other inputs, including mid-lap and in ERROR.
REQ-025 After reset release, the first valid one-hot sample SHALL lock without checking rotation.

Structure
REQ-026 The FSM state enum, one-hot constants (0001/0010/0100/1000) and err_code values SHALL live in shared package anel_pkg.
REQ-027 One-hot validity and index decode SHALL be a combinational sub-module onehot_dec (in: 4-bit word; out: valid, 2-bit index).

Verification
REQ-028 Reset, then valid samples 0001,0010,0100,1000,0001 -> locked=1 after first, pos 0,1,2,3,0, lap_count=1 after last.
REQ-029 Locked at 0010, sample 0110 -> err=1, err_code=01, locked=0; later samples 0100, 1000 leave pos=1, err_code=01.
REQ-030 Locked at 0100, sample 0100 -> err_code=11; then clr_err pulse -> err=0, lap_count=0, UNLOCKED; next 1000 relocks with pos=3.
REQ-031 LAP_W=2, 4 full laps from 0001 -> lap_count 1,2,3,0, err stays 0; ring_valid low for 3 cycles mid-lap changes nothing.
REQ-032 Locked at 0001 with lap_count=2, reset=0 for one cycle while ring_valid=1 and ring_in=0010 -> all outputs 0, UNLOCKED; clr_err with valid 1000 same cycle -> sample discarded, pos=0.

Source files
------------

// File: rtl/anel_pkg.sv
// Shared types and constants for the ring-counter monitor.
package anel_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'b00,
    ERR_NOT_ONEHOT = 2'b01,
    ERR_WRONG_STEP = 2'b10,
    ERR_STALL      = 2'b11
  } err_code_e;

  localparam logic [3:0] OH_0 = 4'b0001;
  localparam logic [3:0] OH_1 = 4'b0010;
  localparam logic [3:0] OH_2 = 4'b0100;
  localparam logic [3:0] OH_3 = 4'b1000;

  // One-hot word for a ring position.
  function automatic logic [3:0] oh_of(input logic [1:0] idx);
    logic [3:0] w;
    case (idx)
      2'd0:    w = OH_0;
      2'd1:    w = OH_1;
      2'd2:    w = OH_2;
      default: w = OH_3;
    endcase
    return w;
  endfunction

  // Ring advance: rotate left by one, top bit wraps to bit 0.
  function automatic logic [3:0] rotl1(input logic [3:0] w);
    return {w[2:0], w[3]};
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational one-hot check and index decode of a 4-bit ring word.
module onehot_dec
  import anel_pkg::*;
(
  input  logic [3:0] word_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  // Only the four legal ring words decode as valid; zero and multi-bit words do not.
  always_comb begin
    valid_o = 1'b1;
    idx_o   = 2'd0;
    case (word_i)
      OH_0:    idx_o = 2'd0;
      OH_1:    idx_o = 2'd1;
      OH_2:    idx_o = 2'd2;
      OH_3:    idx_o = 2'd3;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/monitor_anel.sv
// Monitors a 4-bit one-hot ring counter: locks on the first legal word,
// then checks every valid sample is the previous one rotated left by one.
// Counts wraps while locked and latches the first error cause.
module monitor_anel
  import anel_pkg::*;
#(
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ring_in,
  input  logic             ring_valid,
  input  logic             clr_err,
  output logic [1:0]       pos,
  output logic             locked,
  output logic [LAP_W-1:0] lap_count,
  output logic             err,
  output logic [1:0]       err_code
);

  state_e           state_q, state_d;
  logic [1:0]       pos_q, pos_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             err_q, err_d;
  err_code_e        code_q, code_d;

  logic             oh_vld;
  logic [1:0]       oh_idx;

  onehot_dec u_dec (
    .word_i  (ring_in),
    .valid_o (oh_vld),
    .idx_o   (oh_idx)
  );

  // State and output registers; reset is synchronous and active low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_UNLOCKED;
      pos_q   <= 2'd0;
      lap_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      lap_q   <= lap_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Next state: clear beats any sample; invalid cycles hold everything.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    lap_d   = lap_q;
    err_d   = err_q;
    code_d  = code_q;
    if (clr_err) begin
      state_d = ST_UNLOCKED;
      pos_d   = 2'd0;
      lap_d   = '0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
    end else if (ring_valid) begin
      case (state_q)
        ST_UNLOCKED: begin
          // First legal word locks without a rotation check.
          if (oh_vld) begin
            pos_d   = oh_idx;
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (!oh_vld) begin
            err_d   = 1'b1;
            code_d  = ERR_NOT_ONEHOT;
            state_d = ST_ERROR;
          end else if (ring_in == rotl1(oh_of(pos_q))) begin
            pos_d = oh_idx;
            // 1000 -> 0001 is a completed lap; counter wraps silently.
            if (pos_q == 2'd3) lap_d = lap_q + LAP_W'(1);
          end else if (oh_idx == pos_q) begin
            err_d   = 1'b1;
            code_d  = ERR_STALL;
            state_d = ST_ERROR;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_WRONG_STEP;
            state_d = ST_ERROR;
          end
        end
        ST_ERROR: ;
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  assign pos       = pos_q;
  assign locked    = (state_q == ST_LOCKED);
  assign lap_count = lap_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_monitor_anel.sv
// Directed bench for monitor_anel: one default-width instance and one with
// a 2-bit lap counter, both fed the same stimulus.
module tb_monitor_anel;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ring_in = 4'b0000;
  logic       ring_valid = 1'b0;
  logic       clr_err = 1'b0;

  logic [1:0] pos_a, code_a, pos_b, code_b;
  logic       locked_a, err_a, locked_b, err_b;
  logic [7:0] lap_a;
  logic [1:0] lap_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  monitor_anel #(.LAP_W(8)) dut_a (
    .clk(clk), .reset(reset), .ring_in(ring_in), .ring_valid(ring_valid),
    .clr_err(clr_err), .pos(pos_a), .locked(locked_a), .lap_count(lap_a),
    .err(err_a), .err_code(code_a)
  );

  monitor_anel #(.LAP_W(2)) dut_b (
    .clk(clk), .reset(reset), .ring_in(ring_in), .ring_valid(ring_valid),
    .clr_err(clr_err), .pos(pos_b), .locked(locked_b), .lap_count(lap_b),
    .err(err_b), .err_code(code_b)
  );

  // {locked, pos, err, err_code} of the 8-bit instance
  wire [5:0] obs_a = {locked_a, pos_a, err_a, code_a};
  wire [5:0] obs_b = {locked_b, pos_b, err_b, code_b};

  // One clock: drive on falling edge, outputs settle #1 after rising edge.
  task automatic step(input logic v, input logic [3:0] w, input logic c, input logic r);
    @(negedge clk);
    ring_valid = v; ring_in = w; clr_err = c; reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    tests++;
    if (obs_a !== 6'b0_00_0_00 || lap_a !== 8'd0) begin
      fails++; $display("FAIL reset_a obs=%b lap=%0d exp obs=000000 lap=0", obs_a, lap_a);
    end
    tests++;
    if (obs_b !== 6'b0_00_0_00 || lap_b !== 2'd0) begin
      fails++; $display("FAIL reset_b obs=%b lap=%0d exp obs=000000 lap=0", obs_b, lap_b);
    end
  endtask

  task automatic test_lap;
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] ep [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0, 1'b1);
      tests++;
      if (obs_a !== {1'b1, ep[i], 3'b0_00}) begin
        fails++; $display("FAIL lap_seq%0d obs=%b exp=%b", i, obs_a, {1'b1, ep[i], 3'b0_00});
      end
    end
    tests++;
    if (lap_a !== 8'd1) begin
      fails++; $display("FAIL lap_count got %0d exp 1", lap_a);
    end
  endtask

  task automatic test_not_onehot;
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 4'b0001, 1'b0, 1'b1);
    step(1'b1, 4'b0010, 1'b0, 1'b1);
    step(1'b1, 4'b0110, 1'b0, 1'b1);
    tests++;
    if (obs_a !== 6'b0_01_1_01) begin
      fails++; $display("FAIL not_onehot obs=%b exp=001101", obs_a);
    end
    step(1'b1, 4'b0100, 1'b0, 1'b1);
    step(1'b1, 4'b1000, 1'b0, 1'b1);
    tests++;
    if (obs_a !== 6'b0_01_1_01) begin
      fails++; $display("FAIL err_hold obs=%b exp=001101", obs_a);
    end
  endtask

  task automatic test_stall_clear;
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 4'b0100, 1'b0, 1'b1);
    step(1'b1, 4'b0100, 1'b0, 1'b1);
    tests++;
    if (obs_a !== 6'b0_10_1_11) begin
      fails++; $display("FAIL stall obs=%b exp=010111", obs_a);
    end
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    tests++;
    if (obs_a !== 6'b0_00_0_00 || lap_a !== 8'd0) begin
      fails++; $display("FAIL clr obs=%b lap=%0d exp obs=000000 lap=0", obs_a, lap_a);
    end
    step(1'b1, 4'b1000, 1'b0, 1'b1);
    tests++;
    if (obs_a !== 6'b1_11_0_00) begin
      fails++; $display("FAIL relock obs=%b exp=111000", obs_a);
    end
  endtask

  task automatic test_wrong_step;
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 4'b0001, 1'b0, 1'b1);
    step(1'b1, 4'b0100, 1'b0, 1'b1);
    tests++;
    if (obs_a !== 6'b0_00_1_10) begin
      fails++; $display("FAIL wrong_step obs=%b exp=000110", obs_a);
    end
    // zero word while locked is also not one-hot
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 4'b1000, 1'b0, 1'b1);
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    tests++;
    if (obs_a !== 6'b0_11_1_01) begin
      fails++; $display("FAIL zero_word obs=%b exp=011101", obs_a);
    end
  endtask

  task automatic test_wrap;
    logic [1:0] exp_lap;
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 4'b0001, 1'b0, 1'b1);
    for (int lap = 1; lap <= 4; lap++) begin
      step(1'b1, 4'b0010, 1'b0, 1'b1);
      if (lap == 1) begin
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0110, 1'b0, 1'b1);
        tests++;
        if (obs_b !== 6'b1_01_0_00 || lap_b !== 2'd0) begin
          fails++; $display("FAIL idle_hold obs=%b lap=%0d exp obs=101000 lap=0", obs_b, lap_b);
        end
      end
      step(1'b1, 4'b0100, 1'b0, 1'b1);
      step(1'b1, 4'b1000, 1'b0, 1'b1);
      step(1'b1, 4'b0001, 1'b0, 1'b1);
      exp_lap = 2'(lap);
      tests++;
      if (lap_b !== exp_lap || obs_b !== 6'b1_00_0_00) begin
        fails++; $display("FAIL wrap_lap%0d lap=%0d obs=%b exp lap=%0d obs=100000", lap, lap_b, obs_b, exp_lap);
      end
    end
    tests++;
    if (lap_a !== 8'd4) begin
      fails++; $display("FAIL wide_lap got %0d exp 4", lap_a);
    end
  endtask

  task automatic test_reset_midlap;
    logic [3:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 4'b0001, 1'b0, 1'b1);
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0, 1'b1);
    tests++;
    if (lap_a !== 8'd2 || obs_a !== 6'b1_00_0_00) begin
      fails++; $display("FAIL pre_reset lap=%0d obs=%b exp lap=2 obs=100000", lap_a, obs_a);
    end
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    tests++;
    if (lap_a !== 8'd0 || obs_a !== 6'b0_00_0_00) begin
      fails++; $display("FAIL midlap_reset lap=%0d obs=%b exp lap=0 obs=000000", lap_a, obs_a);
    end
    step(1'b1, 4'b0001, 1'b0, 1'b1);
    step(1'b1, 4'b0010, 1'b0, 1'b1);
    step(1'b1, 4'b1000, 1'b1, 1'b1);
    tests++;
    if (obs_a !== 6'b0_00_0_00) begin
      fails++; $display("FAIL clr_priority obs=%b exp=000000", obs_a);
    end
    // reset out of ERROR
    step(1'b1, 4'b0100, 1'b0, 1'b1);
    step(1'b1, 4'b0010, 1'b0, 1'b1);
    tests++;
    if (obs_a !== 6'b0_10_1_10) begin
      fails++; $display("FAIL pre_err_reset obs=%b exp=010110", obs_a);
    end
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    tests++;
    if (obs_a !== 6'b0_00_0_00) begin
      fails++; $display("FAIL err_reset obs=%b exp=000000", obs_a);
    end
  endtask

  initial begin
    test_reset;
    test_lap;
    test_not_onehot;
    test_stall_clear;
    test_wrong_step;
    test_wrap;
    test_reset_midlap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
